// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-neuron chain: default geometry, chain length
// and the parameter-loader state encoding.
package bnn_pkg;

    localparam int DEF_NEURONS   = 8;
    localparam int DEF_INPUTS    = 8;
    localparam int DEF_BIAS_BITS = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Total serial bits the chain holds: each neuron owns its bias and weight bits.
    function automatic int chain_bits(input int neurons, input int inputs, input int bias_bits);
        return neurons * (inputs + bias_bits);
    endfunction

endpackage

// File: rtl/bnn_param_loader.sv
// Serialises parameter words MSB-first onto a daisy-chained neuron array,
// asserting setup only on cycles that carry a real bit, then reports done.
module bnn_param_loader
    import bnn_pkg::*;
#(
    parameter int NEURONS   = DEF_NEURONS,
    parameter int INPUTS    = DEF_INPUTS,
    parameter int BIAS_BITS = DEF_BIAS_BITS,
    parameter int DATA_W    = 8
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              setup,
    output logic              param_in,
    output logic              busy,
    output logic              done,
    output state_t            state_dbg
);

    // Handshake: a word transfers on a rising clk edge where in_valid and
    // in_ready are both high; in_ready never depends on in_valid.

    localparam int CHAIN_BITS = chain_bits(NEURONS, INPUTS, BIAS_BITS);
    localparam int BC_W       = $clog2(CHAIN_BITS + 1);
    localparam int BL_W       = $clog2(DATA_W + 1);

    localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(CHAIN_BITS - 1);
    localparam logic [BL_W-1:0] BYTE_FULL = BL_W'(DATA_W);
    localparam logic [BL_W-1:0] BYTE_ONE  = BL_W'(1);

    state_t            state_q, next_state;
    logic [DATA_W-1:0] buf_q;
    logic [BL_W-1:0]   byte_left_q;
    logic [BC_W-1:0]   bit_cnt_q;

    logic do_load, do_shift, do_clear;

    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= next_state;
    end

    always_comb begin
        next_state = state_q;
        in_ready   = 1'b0;
        setup      = 1'b0;
        param_in   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        do_load    = 1'b0;
        do_shift   = 1'b0;
        do_clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!abort && start) begin
                    next_state = FETCH;
                    do_clear   = 1'b1;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (abort) begin
                    next_state = IDLE;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        do_load    = 1'b1;
                        next_state = SHIFT;
                    end
                end
            end
            SHIFT: begin
                busy = 1'b1;
                // An aborted cycle shifts nothing, so the chain never sees a stray bit.
                if (abort) begin
                    next_state = IDLE;
                end else begin
                    setup    = 1'b1;
                    param_in = buf_q[DATA_W-1];
                    do_shift = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        next_state = DONE;
                    end else if (byte_left_q == BYTE_ONE) begin
                        // Last bit of this word: offer a reload so the stream has no bubble.
                        in_ready = 1'b1;
                        if (in_valid) do_load = 1'b1;
                        else          next_state = FETCH;
                    end
                end
            end
            DONE: begin
                done = 1'b1;
                if (abort) begin
                    next_state = IDLE;
                end else if (start) begin
                    next_state = FETCH;
                    do_clear   = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q       <= '0;
            byte_left_q <= '0;
            bit_cnt_q   <= '0;
        end else begin
            if (do_load) begin
                buf_q       <= in_data;
                byte_left_q <= BYTE_FULL;
            end else if (do_shift) begin
                buf_q       <= buf_q << 1;
                byte_left_q <= byte_left_q - BYTE_ONE;
            end
            if (do_clear)      bit_cnt_q <= '0;
            else if (do_shift) bit_cnt_q <= bit_cnt_q + BC_W'(1);
        end
    end

endmodule

// File: tb/tb_bnn_param_loader.sv
// Bench for bnn_param_loader: a behavioural neuron chain behind the loader,
// a bit-stream scoreboard checked every cycle, and directed load scenarios.
module tb_bnn_param_loader;
    import bnn_pkg::*;

    localparam int DATA_W = 8;
    localparam int CB     = chain_bits(DEF_NEURONS, DEF_INPUTS, DEF_BIAS_BITS);
    localparam int NW     = CB / DATA_W;
    localparam int FIELD  = DEF_INPUTS + DEF_BIAS_BITS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready, setup, param_in, busy, done;
    state_t            state_dbg;

    int checks = 0;
    int failures = 0;

    bnn_param_loader #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .setup(setup), .param_in(param_in), .busy(busy), .done(done),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- neuron chain (head neuron at low bits) ----------------
    logic [CB-1:0] chain = '0;
    always @(posedge clk) if (setup) chain <= {chain[CB-2:0], param_in};

    function automatic logic [DEF_BIAS_BITS-1:0] nbias(input logic [CB-1:0] c, input int n);
        return c[n*FIELD + DEF_INPUTS +: DEF_BIAS_BITS];
    endfunction

    function automatic logic [DEF_INPUTS-1:0] nweights(input logic [CB-1:0] c, input int n);
        return c[n*FIELD +: DEF_INPUTS];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- word source ----------------
    logic [DATA_W-1:0] src_q[$];
    logic [DATA_W-1:0] cur_words[NW];
    bit throttle = 1'b0;
    bit hs = 1'b0;
    int feed_cyc = 0;

    always @(posedge clk) begin
        #1;
        if (hs && src_q.size() > 0) void'(src_q.pop_front());
        feed_cyc++;
        in_valid = (src_q.size() > 0) && (!throttle || (feed_cyc % 4 == 0));
        in_data  = (src_q.size() > 0) ? src_q[0] : '0;
    end

    // ---------------- scoreboard: expected serial bit stream ----------------
    logic [0:0] exp_q[$];
    int pushed = 0;
    int load_bits = 0;

    always @(negedge clk) begin : scoreboard
        logic [0:0] b;
        if (!busy) begin
            exp_q.delete();
            pushed = 0;
            load_bits = 0;
        end
        if (setup) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL setup_without_bit: setup=1 with no pending word bit");
            end else begin
                b = exp_q.pop_front();
                check("param_in_bit", 128'(param_in), 128'(b));
            end
            if (in_ready) check("in_ready_mid_word", 128'(load_bits % DATA_W), 128'(DATA_W - 1));
            load_bits++;
        end
        hs = in_valid && in_ready;
        if (hs) begin
            for (int k = DATA_W - 1; k >= 0; k--) begin
                if (pushed < CB) begin
                    exp_q.push_back(in_data[k]);
                    pushed++;
                end
            end
        end
    end

    // Expected chain image: stream bit k (k=0 first) ends at chain position CB-1-k.
    function automatic logic [CB-1:0] golden();
        logic [CB-1:0] g;
        g = '0;
        for (int k = 0; k < CB; k++) g[CB-1-k] = cur_words[k / DATA_W][DATA_W-1-(k % DATA_W)];
        return g;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic load_words();
        src_q.delete();
        for (int i = 0; i < NW; i++) src_q.push_back(cur_words[i]);
    endtask

    task automatic pulse(input bit s, input bit a);
        @(posedge clk); #2;
        start = s;
        abort = a;
        @(posedge clk); #2;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(output int cnt, output int first, output int last, output int dcyc);
        cnt = 0; first = -1; last = -1; dcyc = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (setup) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
            if (done) begin
                dcyc = i;
                break;
            end
        end
        if (dcyc < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: done not seen within 600 cycles");
        end
    endtask

    task automatic wait_bits(input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < 400 && seen < n; i++) begin
            @(negedge clk);
            if (setup) seen++;
        end
        check("reach_bits", 128'(seen), 128'(n));
    endtask

    task automatic set_golden_words();
        logic [DATA_W-1:0] w [NW];
        w = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h55, 8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9B};
        for (int i = 0; i < NW; i++) cur_words[i] = w[i];
    endtask

    // ---------------- directed scenarios ----------------
    logic [CB-1:0] chain1;
    int cnt, first, last, dcyc;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", 128'({in_ready, setup, param_in, busy, done}), 128'(0));
        check("reset_state", 128'(state_dbg), 128'(IDLE));
        rst_n = 1'b1;

        // 1. Back-to-back load
        set_golden_words();
        @(negedge clk); load_words();
        pulse(1'b1, 1'b0);
        wait_done(cnt, first, last, dcyc);
        check("s1_setup_count", 128'(cnt), 128'(CB));
        check("s1_setup_consecutive", 128'(last - first + 1), 128'(CB));
        check("s1_done_after_last", 128'(dcyc), 128'(last + 1));
        check("s1_chain", 128'(chain), 128'(golden()));
        check("s1_last_bias", 128'(nbias(chain, 7)), 128'(3'b101));
        check("s1_last_weights", 128'(nweights(chain, 7)), 128'(8'h29));
        check("s1_head_bias", 128'(nbias(chain, 0)), 128'(3'b000));
        check("s1_head_weights", 128'(nweights(chain, 0)), 128'(8'h9B));
        chain1 = chain;

        // 2. Throttled source, restarted from DONE
        throttle = 1'b1;
        @(negedge clk); load_words();
        pulse(1'b1, 1'b0);
        wait_done(cnt, first, last, dcyc);
        throttle = 1'b0;
        check("s2_setup_count", 128'(cnt), 128'(CB));
        check("s2_chain_same", 128'(chain), 128'(chain1));

        // 3. Ordering
        for (int i = 0; i < NW; i++) cur_words[i] = '0;
        cur_words[0] = 8'hE0;
        @(negedge clk); load_words();
        pulse(1'b1, 1'b0);
        wait_done(cnt, first, last, dcyc);
        check("s3_chain", 128'(chain), 128'({3'b111, 85'd0}));
        check("s3_last_bias", 128'(nbias(chain, 7)), 128'(3'b111));
        check("s3_model_pin", 128'(golden()), 128'({3'b111, 85'd0}));

        // 4. Abort after 40 bits, then a full reload
        set_golden_words();
        @(negedge clk); load_words();
        pulse(1'b1, 1'b0);
        wait_bits(40);
        @(posedge clk); #2;
        abort = 1'b1;
        @(negedge clk);
        check("s4_abort_cycle_setup", 128'(setup), 128'(0));
        @(posedge clk); #2;
        abort = 1'b0;
        @(negedge clk);
        check("s4_after_abort", 128'({setup, busy, done}), 128'(0));
        check("s4_after_abort_state", 128'(state_dbg), 128'(IDLE));
        src_q.delete();
        load_words();
        pulse(1'b1, 1'b0);
        wait_done(cnt, first, last, dcyc);
        check("s4_reload_chain", 128'(chain), 128'(golden()));
        check("s4_reload_done", 128'(done), 128'(1));

        // 5. Async reset mid-SHIFT, away from the clock edge
        @(negedge clk); load_words();
        pulse(1'b1, 1'b0);
        wait_bits(20);
        #2;
        rst_n = 1'b0;
        #1;
        check("s5_reset_immediate", 128'({setup, in_ready, busy, done}), 128'(0));
        @(posedge clk); #3;
        src_q.delete();
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("s5_state_after_release", 128'(state_dbg), 128'(IDLE));
        check("s5_outputs_after_release", 128'({setup, in_ready, busy, done}), 128'(0));

        // 6. start+abort in DONE, then start alone from DONE
        @(negedge clk); load_words();
        pulse(1'b1, 1'b0);
        wait_done(cnt, first, last, dcyc);
        check("s6_done", 128'(done), 128'(1));
        pulse(1'b1, 1'b1);
        @(negedge clk);
        check("s6_start_abort_state", 128'(state_dbg), 128'(IDLE));
        check("s6_start_abort_done", 128'(done), 128'(0));
        load_words();
        pulse(1'b1, 1'b0);
        wait_done(cnt, first, last, dcyc);
        check("s6_chain", 128'(chain), 128'(golden()));
        pulse(1'b1, 1'b0);
        @(negedge clk);
        check("s6_restart_state", 128'(state_dbg), 128'(FETCH));
        check("s6_restart_ready", 128'({in_ready, done}), 128'(2'b10));
        pulse(1'b0, 1'b1);
        @(negedge clk);
        check("s6_cleanup_idle", 128'(state_dbg), 128'(IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
